// File: rtl/block_animator_pkg.sv
// Shared types and constants for the sliding-block animator.
package block_animator_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ERASE = 3'd1,
      ST_MOVE  = 3'd2,
      ST_DRAW  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam int COLOUR_W = 3;   // adapter colour width
   localparam int DIM_W    = 4;   // block width/height and scan counter width

   localparam logic DIR_RIGHT = 1'b1;
   localparam logic DIR_LEFT  = 1'b0;

   // A requested width of 0 is treated as a 1-pixel block.
   function automatic logic [DIM_W-1:0] eff_width(input logic [DIM_W-1:0] w);
      return (w == '0) ? DIM_W'(1) : w;
   endfunction

endpackage

// File: rtl/block_animator_box_scanner.sv
// Rectangle scanner: px runs fastest, py advances when px wraps.
// Shared by the erase and draw passes; cleared whenever it is idle.
module block_animator_box_scanner
   import block_animator_pkg::*;
(
   input  logic             clk,
   input  logic             resetn,
   input  logic             clr,
   input  logic             en,
   input  logic [DIM_W-1:0] width,
   input  logic [DIM_W-1:0] height,
   output logic [DIM_W-1:0] px,
   output logic [DIM_W-1:0] py,
   output logic             last
);

   logic [DIM_W-1:0] px_q, px_d;
   logic [DIM_W-1:0] py_q, py_d;
   logic             px_end;

   // Next counter values; last flags the final pixel of the rectangle.
   always_comb begin
      px_end = (px_q == width - DIM_W'(1));
      last   = px_end && (py_q == height - DIM_W'(1));
      px_d   = px_q;
      py_d   = py_q;
      if (clr) begin
         px_d = '0;
         py_d = '0;
      end else if (en) begin
         if (px_end) begin
            px_d = '0;
            py_d = last ? '0 : py_q + DIM_W'(1);
         end else begin
            px_d = px_q + DIM_W'(1);
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         px_q <= '0;
         py_q <= '0;
      end else begin
         px_q <= px_d;
         py_q <= py_d;
      end
   end

   assign px = px_q;
   assign py = py_q;

endmodule

// File: rtl/block_animator.sv
// Per-frame erase / step / redraw of a bouncing block, one pixel per cycle.
module block_animator
   import block_animator_pkg::*;
#(
   parameter int                  X_W       = 8,
   parameter int                  Y_W       = 7,
   parameter int                  X_MAX     = 159,
   parameter int                  BOX_H     = 4,
   parameter logic [COLOUR_W-1:0] BG_COLOUR = 3'b000
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                frame_tick,
   input  logic                run,
   input  logic [Y_W-1:0]      row_y,
   input  logic [COLOUR_W-1:0] colour_in,
   input  logic [DIM_W-1:0]    blk_w,
   output logic [X_W-1:0]      x_out,
   output logic [Y_W-1:0]      y_out,
   output logic [COLOUR_W-1:0] colour_out,
   output logic                plot,
   output logic                busy,
   output logic                frame_done,
   output logic [X_W-1:0]      pos_x
);

   localparam logic [X_W:0] XMAX_E = (X_W+1)'(X_MAX);
   localparam logic [X_W:0] ONE_E  = (X_W+1)'(1);

   state_t              state_q, state_d;
   logic                tick_q, tick_d;
   logic [X_W-1:0]      pos_q, pos_d;
   logic                dir_q, dir_d;
   logic [DIM_W-1:0]    drawn_w_q, drawn_w_d;
   logic [Y_W-1:0]      drawn_y_q, drawn_y_d;
   logic [DIM_W-1:0]    w_q, w_d;
   logic [Y_W-1:0]      row_q, row_d;
   logic [COLOUR_W-1:0] colour_q, colour_d;

   logic                rise;
   logic                scan_en;
   logic [DIM_W-1:0]    scan_w, scan_px, scan_py;
   logic                scan_last;

   logic [X_W:0]        pos_e, w_e, pos_c, right_c;
   logic [X_W-1:0]      pos_step;
   logic                dir_step;

   assign scan_en = (state_q == ST_ERASE) || (state_q == ST_DRAW);
   assign scan_w  = (state_q == ST_ERASE) ? drawn_w_q : w_q;

   block_animator_box_scanner u_scan (
      .clk    (clk),
      .resetn (resetn),
      .clr    (!scan_en),
      .en     (scan_en),
      .width  (scan_w),
      .height (DIM_W'(BOX_H)),
      .px     (scan_px),
      .py     (scan_py),
      .last   (scan_last)
   );

   // Clamp a grown block back on screen, then take one bouncing step.
   // One bit of headroom keeps pos+w from wrapping before the compare.
   always_comb begin
      w_e      = (X_W+1)'(w_q);
      pos_e    = (X_W+1)'(pos_q);
      pos_c    = (pos_e + w_e - ONE_E > XMAX_E) ? XMAX_E + ONE_E - w_e : pos_e;
      right_c  = pos_c + w_e - ONE_E;
      dir_step = dir_q;
      pos_step = X_W'(pos_c);
      if (w_e == XMAX_E + ONE_E) begin
         pos_step = '0;
      end else if (dir_q == DIR_RIGHT) begin
         if (right_c == XMAX_E) begin
            dir_step = DIR_LEFT;
            pos_step = X_W'(pos_c - ONE_E);
         end else begin
            pos_step = X_W'(pos_c + ONE_E);
         end
      end else begin
         if (pos_c == '0) begin
            dir_step = DIR_RIGHT;
            pos_step = X_W'(pos_c + ONE_E);
         end else begin
            pos_step = X_W'(pos_c - ONE_E);
         end
      end
   end

   // Frame sequencing: edge detect, parameter latching and the state walk.
   always_comb begin
      rise      = frame_tick & ~tick_q;
      tick_d    = frame_tick;
      state_d   = state_q;
      pos_d     = pos_q;
      dir_d     = dir_q;
      drawn_w_d = drawn_w_q;
      drawn_y_d = drawn_y_q;
      w_d       = w_q;
      row_d     = row_q;
      colour_d  = colour_q;
      unique case (state_q)
         ST_IDLE: begin
            if (rise && run) begin
               row_d    = row_y;
               colour_d = colour_in;
               w_d      = eff_width(blk_w);
               state_d  = (drawn_w_q != '0) ? ST_ERASE : ST_MOVE;
            end
         end
         ST_ERASE: begin
            if (scan_last) state_d = ST_MOVE;
         end
         ST_MOVE: begin
            pos_d   = pos_step;
            dir_d   = dir_step;
            state_d = ST_DRAW;
         end
         ST_DRAW: begin
            if (scan_last) begin
               drawn_w_d = w_q;
               drawn_y_d = row_q;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         tick_q    <= 1'b0;
         pos_q     <= '0;
         dir_q     <= DIR_RIGHT;
         drawn_w_q <= '0;
         drawn_y_q <= '0;
         w_q       <= '0;
         row_q     <= '0;
         colour_q  <= '0;
      end else begin
         state_q   <= state_d;
         tick_q    <= tick_d;
         pos_q     <= pos_d;
         dir_q     <= dir_d;
         drawn_w_q <= drawn_w_d;
         drawn_y_q <= drawn_y_d;
         w_q       <= w_d;
         row_q     <= row_d;
         colour_q  <= colour_d;
      end
   end

   // Pixel outputs come from registered state and counters only; zero when not plotting.
   always_comb begin
      plot       = scan_en;
      busy       = (state_q != ST_IDLE);
      frame_done = (state_q == ST_DONE);
      x_out      = '0;
      y_out      = '0;
      colour_out = '0;
      if (state_q == ST_ERASE) begin
         x_out      = pos_q + X_W'(scan_px);
         y_out      = drawn_y_q + Y_W'(scan_py);
         colour_out = BG_COLOUR;
      end else if (state_q == ST_DRAW) begin
         x_out      = pos_q + X_W'(scan_px);
         y_out      = row_q + Y_W'(scan_py);
         colour_out = colour_q;
      end
   end

   assign pos_x = pos_q;

endmodule

// File: tb/tb_block_animator.sv
// Self-checking bench for block_animator against a frame-level reference model.
module tb_block_animator;

   localparam int BOX_H = 4;
   localparam int X_MAX = 159;

   logic       clk = 1'b0;
   logic       resetn;
   logic       frame_tick;
   logic       run;
   logic [6:0] row_y;
   logic [2:0] colour_in;
   logic [3:0] blk_w;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic [2:0] colour_out;
   logic       plot;
   logic       busy;
   logic       frame_done;
   logic [7:0] pos_x;

   block_animator dut (
      .clk        (clk),
      .resetn     (resetn),
      .frame_tick (frame_tick),
      .run        (run),
      .row_y      (row_y),
      .colour_in  (colour_in),
      .blk_w      (blk_w),
      .x_out      (x_out),
      .y_out      (y_out),
      .colour_out (colour_out),
      .plot       (plot),
      .busy       (busy),
      .frame_done (frame_done),
      .pos_x      (pos_x)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit plot;
      int x;
      int y;
      int c;
      bit done;
   } cyc_t;

   cyc_t exp_q[$];

   // Reference model state: block position, direction (1 = right), what is on screen.
   int m_pos, m_dir, m_drawn_w, m_drawn_y;
   int n_vec, n_err;
   int last_busy, last_plots, last_dones;

   // Expected cycle-by-cycle picture of one frame, and the model's updated state.
   task automatic build_frame(input int row, input int col, input int bw);
      cyc_t r;
      int   w;
      exp_q.delete();
      w = (bw == 0) ? 1 : bw;
      for (int py = 0; py < BOX_H; py++) begin
         for (int px = 0; px < m_drawn_w; px++) begin
            r.plot = 1; r.x = m_pos + px; r.y = (m_drawn_y + py) % 128; r.c = 0; r.done = 0;
            exp_q.push_back(r);
         end
      end
      r.plot = 0; r.x = 0; r.y = 0; r.c = 0; r.done = 0;
      exp_q.push_back(r);
      if (m_pos + w - 1 > X_MAX) m_pos = X_MAX - w + 1;
      if (w == X_MAX + 1) begin
         m_pos = 0;
      end else if (m_dir == 1) begin
         if (m_pos + w - 1 == X_MAX) begin m_dir = 0; m_pos = m_pos - 1; end
         else m_pos = m_pos + 1;
      end else begin
         if (m_pos == 0) begin m_dir = 1; m_pos = m_pos + 1; end
         else m_pos = m_pos - 1;
      end
      for (int py = 0; py < BOX_H; py++) begin
         for (int px = 0; px < w; px++) begin
            r.plot = 1; r.x = m_pos + px; r.y = (row + py) % 128; r.c = col; r.done = 0;
            exp_q.push_back(r);
         end
      end
      r.plot = 0; r.x = 0; r.y = 0; r.c = 0; r.done = 1;
      exp_q.push_back(r);
      m_drawn_w = w;
      m_drawn_y = row;
   endtask

   task automatic model_reset();
      m_pos = 0; m_dir = 1; m_drawn_w = 0; m_drawn_y = 0;
   endtask

   // Request one frame and check every cycle of it. Inputs are scrambled after the
   // request to show they were latched; toggle adds a second rise while busy.
   task automatic do_frame(input int row, input int col, input int bw,
                           input bit toggle, input bit keep_high, input string tag);
      build_frame(row, col, bw);
      last_busy = 0; last_plots = 0; last_dones = 0;
      @(negedge clk);
      row_y = 7'(row); colour_in = 3'(col); blk_w = 4'(bw); run = 1'b1; frame_tick = 1'b1;
      foreach (exp_q[k]) begin
         @(posedge clk); #1;
         last_busy  += int'(busy);
         last_plots += int'(plot);
         last_dones += int'(frame_done);
         n_vec++;
         if (plot !== exp_q[k].plot || busy !== 1'b1 || frame_done !== exp_q[k].done ||
             x_out !== 8'(exp_q[k].x) || y_out !== 7'(exp_q[k].y) || colour_out !== 3'(exp_q[k].c)) begin
            n_err++;
            $display("FAIL %s cyc%0d: got plot=%b x=%0d y=%0d c=%0d busy=%b done=%b; want plot=%b x=%0d y=%0d c=%0d busy=1 done=%b",
                     tag, k, plot, x_out, y_out, colour_out, busy, frame_done,
                     exp_q[k].plot, exp_q[k].x, exp_q[k].y, exp_q[k].c, exp_q[k].done);
         end
         if (k == 0) begin
            row_y = 7'($urandom); colour_in = 3'($urandom); blk_w = 4'($urandom); run = 1'($urandom);
         end
         if (toggle && k == 2) frame_tick = 1'b0;
         if (toggle && k == 4) frame_tick = 1'b1;
      end
      @(posedge clk); #1;
      last_dones += int'(frame_done);
      n_vec++;
      if (busy !== 1'b0 || plot !== 1'b0 || frame_done !== 1'b0) begin
         n_err++;
         $display("FAIL %s idle: got busy=%b plot=%b done=%b; want 0 0 0", tag, busy, plot, frame_done);
      end
      n_vec++;
      if (pos_x !== 8'(m_pos)) begin
         n_err++;
         $display("FAIL %s pos_x: got %0d want %0d", tag, pos_x, m_pos);
      end
      $display("frame %s: w=%0d row=%0d col=%0d -> pos_x=%0d (%0d cycles)", tag, bw, row, col, pos_x, exp_q.size());
      if (!keep_high) begin
         frame_tick = 1'b0;
         @(posedge clk);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0; frame_tick = 1'b0; run = 1'b1; row_y = '0; colour_in = '0; blk_w = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (plot !== 0 || busy !== 0 || frame_done !== 0 || pos_x !== 0 ||
          x_out !== 0 || y_out !== 0 || colour_out !== 0) begin
         n_err++;
         $display("FAIL reset: got plot=%b busy=%b done=%b pos=%0d x=%0d y=%0d c=%0d; want all 0",
                  plot, busy, frame_done, pos_x, x_out, y_out, colour_out);
      end
      @(negedge clk); resetn = 1'b1;
      @(posedge clk);
      $display("reset released");
   endtask

   task automatic test_first_frame();
      do_frame(10, 3'b100, 4, 1'b0, 1'b0, "first");
      n_vec++;
      if (pos_x !== 8'd1 || last_plots != 16 || last_busy != 18 || last_dones != 1) begin
         n_err++;
         $display("FAIL first_summary: got pos=%0d plots=%0d busy=%0d dones=%0d; want 1 16 18 1",
                  pos_x, last_plots, last_busy, last_dones);
      end
   endtask

   task automatic test_second_frame();
      do_frame(10, 3'b100, 4, 1'b0, 1'b0, "second");
      n_vec++;
      if (pos_x !== 8'd2 || last_plots != 32 || last_busy != 34) begin
         n_err++;
         $display("FAIL second_summary: got pos=%0d plots=%0d busy=%0d; want 2 32 34",
                  pos_x, last_plots, last_busy);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         do_frame(int'($urandom_range(124, 0)), int'($urandom_range(7, 0)),
                  int'($urandom_range(15, 0)), 1'b0, 1'b0, "random");
      end
   endtask

   // Run 4-wide frames until the model sits at the given position and direction.
   task automatic walk_to(input int pos, input int dir, input string tag);
      int guard;
      guard = 0;
      while (!(m_pos == pos && m_dir == dir) && guard < 400) begin
         do_frame(int'($urandom_range(124, 0)), int'($urandom_range(7, 0)), 4, 1'b0, 1'b0, tag);
         guard++;
      end
      n_vec++;
      if (guard >= 400) begin
         n_err++;
         $display("FAIL %s walk: got pos=%0d after %0d frames, want pos %0d", tag, pos_x, guard, pos);
      end
   endtask

   task automatic test_bounce();
      walk_to(156, 1, "walk_r");
      do_frame(20, 2, 4, 1'b0, 1'b0, "bounce_r");
      n_vec++;
      if (pos_x !== 8'd155) begin
         n_err++;
         $display("FAIL bounce_right: got %0d want 155", pos_x);
      end
      walk_to(0, 0, "walk_l");
      do_frame(20, 2, 4, 1'b0, 1'b0, "bounce_l");
      n_vec++;
      if (pos_x !== 8'd1) begin
         n_err++;
         $display("FAIL bounce_left: got %0d want 1", pos_x);
      end
   endtask

   task automatic test_held_tick();
      int dones;
      do_frame(30, 5, 4, 1'b1, 1'b1, "held");
      dones = last_dones;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         dones += int'(frame_done);
         n_vec++;
         if (busy !== 1'b0 || plot !== 1'b0) begin
            n_err++;
            $display("FAIL held_idle cyc%0d: got busy=%b plot=%b want 0 0", i, busy, plot);
         end
      end
      n_vec++;
      if (dones != 1) begin
         n_err++;
         $display("FAIL held_dones: got %0d want 1", dones);
      end
      frame_tick = 1'b0;
      @(posedge clk);
   endtask

   task automatic test_run_off();
      int events;
      events = 0;
      @(negedge clk);
      run = 1'b0; frame_tick = 1'b1; blk_w = 4'd6;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         events += int'(plot) + int'(frame_done) + int'(busy);
      end
      n_vec++;
      if (events != 0 || pos_x !== 8'(m_pos)) begin
         n_err++;
         $display("FAIL run_off: got activity=%0d pos=%0d; want 0 %0d", events, pos_x, m_pos);
      end
      $display("frame run_off: pos_x=%0d", pos_x);
      frame_tick = 1'b0;
      @(posedge clk);
      run = 1'b1;
   endtask

   task automatic test_grow();
      walk_to(156, 1, "walk_g");
      do_frame(40, 6, 8, 1'b0, 1'b0, "grow");
      n_vec++;
      if (pos_x !== 8'd151) begin
         n_err++;
         $display("FAIL grow_pos: got %0d want 151", pos_x);
      end
   endtask

   task automatic test_reset_mid_draw();
      int stop;
      stop = m_drawn_w * BOX_H + 1 + 3;
      build_frame(50, 7, 5);
      @(negedge clk);
      row_y = 7'd50; colour_in = 3'd7; blk_w = 4'd5; run = 1'b1; frame_tick = 1'b1;
      for (int k = 0; k < stop; k++) begin
         @(posedge clk); #1;
         n_vec++;
         if (plot !== exp_q[k].plot || x_out !== 8'(exp_q[k].x) || y_out !== 7'(exp_q[k].y)) begin
            n_err++;
            $display("FAIL rstmid cyc%0d: got plot=%b x=%0d y=%0d; want plot=%b x=%0d y=%0d",
                     k, plot, x_out, y_out, exp_q[k].plot, exp_q[k].x, exp_q[k].y);
         end
      end
      resetn = 1'b0;
      #1;
      n_vec++;
      if (plot !== 1'b0 || busy !== 1'b0 || pos_x !== 8'd0 || x_out !== 8'd0) begin
         n_err++;
         $display("FAIL rstmid_abort: got plot=%b busy=%b pos=%0d x=%0d; want 0 0 0 0",
                  plot, busy, pos_x, x_out);
      end
      $display("reset mid-draw: plot=%b pos_x=%0d", plot, pos_x);
      model_reset();
      frame_tick = 1'b0;
      @(negedge clk); resetn = 1'b1;
      @(posedge clk);
      do_frame(60, 3, 4, 1'b0, 1'b0, "after_rst");
      n_vec++;
      if (last_plots != 16 || pos_x !== 8'd1) begin
         n_err++;
         $display("FAIL after_rst: got plots=%0d pos=%0d; want 16 1", last_plots, pos_x);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_first_frame();
      test_second_frame();
      test_random();
      test_bounce();
      test_held_tick();
      test_run_off();
      test_grow();
      test_reset_mid_draw();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
